// File: rtl/fa_cout_pkg.sv
// Shared constants for the fa_cout block.
package fa_cout_pkg;

    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/fa_cout_maj3.sv
// Three-input majority gate: the carry-out of a full adder.
module maj3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fa_cout.sv
// Full-adder carry-out with a registered copy and a saturating carry-event counter.
module fa_cout
    import fa_cout_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             en,
    output logic             cout,
    output logic             cout_q,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    maj3 u_maj3 (
        .a (a),
        .b (b),
        .c (c),
        .y (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout_q    <= 1'b0;
            carry_cnt <= '0;
        end else if (en) begin
            cout_q <= cout;
            // Counter sticks at its maximum rather than wrapping.
            if (cout && (carry_cnt != CNT_MAX)) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end
    end

    assign cnt_sat = (carry_cnt == CNT_MAX);

endmodule

// File: tb/tb_fa_cout.sv
// Self-checking bench for fa_cout (CNT_W=2): arithmetic model plus directed vectors.
`timescale 1ns/100ps
module tb_fa_cout;

    localparam int CNT_W = 2;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a = 1'b0, b = 1'b0, c = 1'b0, en = 1'b0;
    logic             cout, cout_q, cnt_sat;
    logic [CNT_W-1:0] carry_cnt;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    // Model state: expected registered carry and counter value.
    int m_q   = 0;
    int m_cnt = 0;

    fa_cout #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .en        (en),
        .cout      (cout),
        .cout_q    (cout_q),
        .carry_cnt (carry_cnt),
        .cnt_sat   (cnt_sat)
    );

    always #5 clk = ~clk;

    function automatic int maj_ref(logic x, logic y, logic z);
        return ((int'(x) + int'(y) + int'(z)) >= 2) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   <= 0;
            m_cnt <= 0;
        end else if (en) begin
            m_q <= maj_ref(a, b, c);
            if (maj_ref(a, b, c) == 1 && m_cnt < MAXV) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_cout",    32'(cout),      32'(maj_ref(a, b, c)));
            chk("model_cout_q",  32'(cout_q),    32'(m_q));
            chk("model_cnt",     32'(carry_cnt), 32'(m_cnt));
            chk("model_cnt_sat", 32'(cnt_sat),   32'(m_cnt == MAXV));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input string tag);
        logic [7:0] tt;
        logic [2:0] v;
        tt = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, c} = v;
            #0.5;
            chk({tag, "_tt"},    32'(cout), 32'(tt[i]));
            chk({tag, "_model"}, 32'(cout), 32'(maj_ref(a, b, c)));
            #0.5;
        end
        {a, b, c} = 3'b000;
    endtask

    initial begin
        int exp_seq[5];
        exp_seq = '{1, 2, 3, 3, 3};

        #2;
        chk("rst_cout_q",  32'(cout_q),    32'd0);
        chk("rst_cnt",     32'(carry_cnt), 32'd0);
        chk("rst_cnt_sat", 32'(cnt_sat),   32'd0);
        sweep("sweep_in_rst");
        chk("rst_hold_q",  32'(cout_q),    32'd0);

        @(negedge clk);
        rst = 1'b0;
        model_on = 1'b1;
        sweep("sweep_run");

        // Registered carry: one-cycle latency, then hold with en low.
        @(negedge clk);
        {a, b, c} = 3'b110;
        en = 1'b1;
        #1;
        chk("q_before_edge", 32'(cout_q), 32'd0);
        tick();
        chk("q_after_edge", 32'(cout_q), 32'd1);
        {a, b, c} = 3'b000;
        en = 1'b0;
        tick();
        chk("q_hold", 32'(cout_q), 32'd1);
        tick();
        chk("q_hold2", 32'(cout_q), 32'd1);

        // Saturation sequence from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        {a, b, c} = 3'b111;
        en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sat_seq_cnt", 32'(carry_cnt), 32'(exp_seq[i]));
            chk("sat_seq_flag", 32'(cnt_sat), 32'(exp_seq[i] == 3));
        end

        // Count 2 then carry-free inputs leave it alone.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        tick();
        chk("cnt_at_2", 32'(carry_cnt), 32'd2);
        {a, b, c} = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("cnt_no_carry", 32'(carry_cnt), 32'd2);
        end

        // Async reset mid-cycle with state at 3 / 1.
        {a, b, c} = 3'b111;
        tick();
        chk("pre_rst_cnt", 32'(carry_cnt), 32'd3);
        chk("pre_rst_q",   32'(cout_q),    32'd1);
        #1;
        rst = 1'b1;
        #0.5;
        chk("async_rst_cnt", 32'(carry_cnt), 32'd0);
        chk("async_rst_q",   32'(cout_q),    32'd0);
        chk("async_rst_sat", 32'(cnt_sat),   32'd0);
        {a, b, c} = 3'b010;
        #0.5;
        chk("rst_cout_010", 32'(cout), 32'd0);
        {a, b, c} = 3'b011;
        #0.5;
        chk("rst_cout_011", 32'(cout), 32'd1);
        tick();
        chk("rst_over_en_cnt", 32'(carry_cnt), 32'd0);
        chk("rst_over_en_q",   32'(cout_q),    32'd0);

        // First edge after release behaves normally.
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        {a, b, c} = 3'b011;
        tick();
        chk("release_cnt", 32'(carry_cnt), 32'd1);
        chk("release_q",   32'(cout_q),    32'd1);

        @(negedge clk);
        #1;
        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
